gpu_cmd_sched: RTL and testbench
================================

// Module: gpu_cmd_sched
// PURPOSE
//  Shares the GPU's single 16-bit command input (cpuline) between NREQ requesters.
//  - Each requester offers one {cmd, param} pair through a valid/ready handshake.
//  - Round-robin arbitration picks one requester per command slot.
//  - Serialises the pair onto cpuline, phase-locked to the GPU's two-word fetch
//    (cmd word, param word, one execute cycle).
//  - Filters illegal opcodes and counts issued commands.
// PARAMETERS
//  NREQ   2   number of requesters (1..8)
// PORTS
//  clk          in   1         single system clock, all logic on posedge
//  clr          in   1         synchronous reset, active-high
//  req_valid    in   NREQ      requester i holds a command
//  req_cmd      in   16*NREQ   opcode of requester i, bits [16i+15:16i]
//  req_param    in   16*NREQ   parameter of requester i, same packing
//  req_ready    out  NREQ      one-hot pulse; the pair is consumed when valid&ready
//  vblank       in   1         vertical blank from the TXT timing; used only with the macro
//  cpuline      out  16        registered word driven to the GPU
//  grant_id     out  3         index of the last consumed requester
//  busy         out  1         1 in states CMD, PAR and EXE
//  err_illegal  out  1         1-cycle pulse when an illegal opcode is dropped
//  cmd_count    out  16        number of commands issued, wraps at 0xFFFF->0x0000
// BEHAVIOUR
//  Reset values (cycle after clr is sampled high):
//   - state=NOP0, cpuline=0, req_ready=0, grant_id=0, busy=0, err_illegal=0,
//     cmd_count=0, rr pointer=0.
//  FSM states (each named for the word cpuline holds during that cycle):
//   - NOP0 (0x0000, GPU latching cmd)   -> NOP1
//   - NOP1 (0x0000, GPU latching param) -> CMD if a legal grant, else NOP0
//   - CMD  (held cmd)                   -> PAR
//   - PAR  (held param)                 -> EXE
//   - EXE  (0x0000, GPU executing)      -> CMD if a legal grant, else NOP0
//  Arbitration:
//   - Happens only in NOP1 and EXE.
//   - Round-robin starts at rr+1 mod NREQ.
//   - The winner gets req_ready=1 in that same cycle.
//   - cmd and param are captured into hold registers; rr<=winner; grant_id<=winner.
//   - A requester must keep valid/cmd/param stable until it gets ready.
//  Legal opcodes: 0x00C0..0x00C6.
//   - Any other value, including 0x0000, is consumed (ready pulses) but not issued.
//   - err_illegal pulses in the next cycle; FSM takes the no-grant transition.
//  cmd_count increments on each CMD entry.
//  Throughput and latency:
//   - Back-to-back commands take 3 cycles each (CMD, PAR, EXE).
//   - The grant-cycle to cmd-on-cpuline latency is 1.
//  Idle: cpuline stays 0 and NOP0/NOP1 alternate forever, tracking the GPU nopstate toggle.
//  Start-up: clr release must coincide with GPU nopstate=0 (power-up init).
//  Reset mid-operation:
//   - Aborts the held command; no re-ack is given.
//   - If clr hits in CMD, the GPU executes that cmd with param 0x0000.
//   - Callers therefore assert clr only while idle or at power-up.
//  Simultaneous valid from all requesters: strict rotation, no starvation;
//   NREQ=1 always grants requester 0.
// CONFIGURATION
//  GPU_SCHED_VBLANK_EN defined:
//   - Requesters with index >=1 are eligible only while vblank=1.
//   - Requester 0 is always eligible.
//  Not defined: vblank is ignored; all requesters are always eligible.
// STRUCTURE
//  Package gpu_sched_pkg:
//   - opcode constants OP_INIT=C0, OP_PUTC=C1, OP_BKSP=C2, OP_SETY=C3, OP_SETX=C4,
//     OP_CLS=C5, OP_NL=C6;
//   - state encoding NOP0/NOP1/CMD/PAR/EXE;
//   - legality function.
//  Sub-module rr_arbiter (NREQ request mask in, rr pointer in, one-hot grant out,
//   combinational).
// TESTING
//  1. Reset release, req0 PUTC 0x0041 valid at NOP1:
//     ready0 pulse; cpuline 0x00C1, 0x0041, 0x0000; cmd_count=1.
//  2. req0 and req1 valid continuously, NREQ=2:
//     grants alternate 0,1,0,1; commands 3 cycles apart; no NOP cycles between.
//  3. req1 cmd 0x0055: ready1 pulse; err_illegal=1 one cycle; cpuline stays 0; cmd_count unchanged.
//  4. Idle 10 cycles, then SETX 0x0005:
//     cmd appears only in the cycle after a NOP1; the GPU model shows tmpx=5.
//  5. GPU_SCHED_VBLANK_EN defined, vblank=0, req1 valid: no grant; req0 still served.
//     Set vblank=1: req1 granted at the next NOP1/EXE.
//  6. cmd_count preloaded via 65535 issues, then one more issue: cmd_count=0x0000.
//     clr in NOP1 with req0 valid: no ready pulse, outputs at reset values.

Source files
------------

// File: rtl/gpu_sched_pkg.sv
// Shared definitions for the GPU command scheduler: GPU opcode constants,
// scheduler state encoding and the opcode legality check.
package gpu_sched_pkg;

    // GPU command opcodes accepted on cpuline.
    localparam logic [15:0] OP_INIT = 16'h00C0;
    localparam logic [15:0] OP_PUTC = 16'h00C1;
    localparam logic [15:0] OP_BKSP = 16'h00C2;
    localparam logic [15:0] OP_SETY = 16'h00C3;
    localparam logic [15:0] OP_SETX = 16'h00C4;
    localparam logic [15:0] OP_CLS  = 16'h00C5;
    localparam logic [15:0] OP_NL   = 16'h00C6;

    // Each state is named after the word cpuline carries while in it.
    //   NOP0 : 0x0000, GPU latching its cmd word
    //   NOP1 : 0x0000, GPU latching its param word (arbitration slot)
    //   CMD  : held opcode
    //   PAR  : held parameter
    //   EXE  : 0x0000, GPU executing (arbitration slot)
    typedef enum logic [2:0] {
        NOP0 = 3'd0,
        NOP1 = 3'd1,
        CMD  = 3'd2,
        PAR  = 3'd3,
        EXE  = 3'd4
    } sched_state_t;

    // An opcode is issued only if the GPU knows it; everything else
    // (including 0x0000, which the GPU would read as a NOP) is dropped.
    function automatic logic op_is_legal(input logic [15:0] op);
        case (op)
            OP_INIT, OP_PUTC, OP_BKSP, OP_SETY,
            OP_SETX, OP_CLS, OP_NL: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gpu_cmd_sched_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the requester
// after the pointer and wraps, so the last winner has the lowest priority.
module rr_arbiter
    import gpu_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant
);

    logic found;
    int   idx;

    // Walk ptr+1 .. ptr+NREQ (mod NREQ) and grant the first active request.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_cmd_sched.sv
// GPU command scheduler: shares the GPU's 16-bit cpuline among NREQ
// requesters. Each requester offers a {cmd, param} pair; a round-robin
// arbiter picks one per command slot and the pair is serialised in lock
// step with the GPU's fetch (cmd word, param word, execute cycle).
//
// Handshake: a requester raises req_valid with req_cmd/req_param and keeps
// all three stable until it sees req_ready high in a cycle; the pair is
// consumed in that cycle (valid & ready). req_ready is one-hot and only
// ever high in NOP1 or EXE.
//
// Optional feature: define GPU_SCHED_VBLANK_EN to restrict requesters with
// index >= 1 to vertical blank (vblank=1). Requester 0 is always eligible.
module gpu_cmd_sched
    import gpu_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_cmd,
    input  logic [16*NREQ-1:0] req_param,
    output logic [NREQ-1:0]    req_ready,
    input  logic               vblank,
    output logic [15:0]        cpuline,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               err_illegal,
    output logic [15:0]        cmd_count,
    output logic [2:0]         dbg_state
);

    sched_state_t    state_q;
    sched_state_t    state_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] arb_grant;
    logic [2:0]      rr_q;
    logic [2:0]      sel_idx;
    logic [15:0]     sel_cmd;
    logic [15:0]     sel_param;
    logic            arb_slot;
    logic            take;
    logic            take_legal;
    logic [15:0]     cpuline_d;
    logic [15:0]     hold_param_q;
    logic [15:0]     count_q;

`ifdef GPU_SCHED_VBLANK_EN
    // Secondary requesters may only talk to the GPU during vertical blank.
    always_comb begin
        elig    = {NREQ{vblank}};
        elig[0] = 1'b1;
    end
`else
    logic unused_vblank;
    assign unused_vblank = vblank;

    // Without the vblank gate every requester is always eligible.
    always_comb begin
        elig = '1;
    end
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid & elig),
        .ptr   (rr_q),
        .grant (arb_grant)
    );

    // Convert the one-hot grant into an index and pick that requester's pair.
    always_comb begin
        sel_idx   = 3'd0;
        sel_cmd   = 16'h0000;
        sel_param = 16'h0000;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_idx   = 3'(i);
                sel_cmd   = req_cmd[16*i +: 16];
                sel_param = req_param[16*i +: 16];
            end
        end
    end

    // A pair is consumed only in the two arbitration slots, never in reset.
    // Illegal opcodes are still consumed so the requester is not stuck.
    always_comb begin
        arb_slot   = (state_q == NOP1) || (state_q == EXE);
        take       = arb_slot && (|arb_grant) && !clr;
        take_legal = take && op_is_legal(sel_cmd);
        req_ready  = take ? arb_grant : '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= NOP0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the next word for cpuline. cpuline is registered, so
    // the word for the state being entered is prepared here.
    always_comb begin
        state_d   = state_q;
        cpuline_d = 16'h0000;
        case (state_q)
            NOP0: state_d = NOP1;
            NOP1: begin
                if (take_legal) begin
                    state_d   = CMD;
                    cpuline_d = sel_cmd;
                end else begin
                    state_d = NOP0;
                end
            end
            CMD: begin
                state_d   = PAR;
                cpuline_d = hold_param_q;
            end
            PAR: state_d = EXE;
            EXE: begin
                if (take_legal) begin
                    state_d   = CMD;
                    cpuline_d = sel_cmd;
                end else begin
                    state_d = NOP0;
                end
            end
            default: state_d = NOP0;
        endcase
    end

    // Datapath registers: output word, hold register, rotation pointer,
    // last-grant index, illegal-opcode pulse and issued-command counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            cpuline      <= 16'h0000;
            hold_param_q <= 16'h0000;
            rr_q         <= 3'd0;
            grant_id     <= 3'd0;
            err_illegal  <= 1'b0;
            count_q      <= 16'h0000;
        end else begin
            cpuline     <= cpuline_d;
            err_illegal <= take && !take_legal;
            if (take) begin
                hold_param_q <= sel_param;
                rr_q         <= sel_idx;
                grant_id     <= sel_idx;
            end
            if (take_legal) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    // Status outputs derived from registered state.
    always_comb begin
        busy      = (state_q == CMD) || (state_q == PAR) || (state_q == EXE);
        cmd_count = count_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_gpu_cmd_sched.sv
// Self-checking bench for gpu_cmd_sched (NREQ=2). A slot-level reference
// model predicts the cpuline word stream, ready pulses and counters; a small
// GPU fetch model consumes the DUT's cpuline to confirm phase alignment.
module tb_gpu_cmd_sched;
    import gpu_sched_pkg::*;

    localparam int NREQ = 2;

    logic               clk = 1'b0;
    logic               clr = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [16*NREQ-1:0] req_cmd = '0;
    logic [16*NREQ-1:0] req_param = '0;
    logic [NREQ-1:0]    req_ready;
    logic               vblank = 1'b0;
    logic [15:0]        cpuline;
    logic [2:0]         grant_id;
    logic               busy;
    logic               err_illegal;
    logic [15:0]        cmd_count;
    logic [2:0]         dbg_state;

    gpu_cmd_sched #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .clr         (clr),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_param   (req_param),
        .req_ready   (req_ready),
        .vblank      (vblank),
        .cpuline     (cpuline),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_illegal (err_illegal),
        .cmd_count   (cmd_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    // exp_q: expected {busy, cpuline} for each upcoming cycle of the current
    // slot. A slot is either 2 idle cycles or 3 command cycles; the last
    // cycle of a slot is where the next requester is chosen.
    logic [16:0] exp_q[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    logic [NREQ-1:0] held = '0;
    logic [NREQ-1:0] consumed = '0;

    int          vectors = 0;
    int          miscompares = 0;
    int          m_last;
    int          m_issued;
    logic [15:0] m_count;
    logic [2:0]  m_grant;
    logic        m_err;
    logic        in_reset = 1'b1;
    int          gap_pct = 0;
    logic        vb_rand = 1'b0;

    // GPU fetch model: phase 0 reads cmd, phase 1 reads param, phase 2 runs.
    int          g_ph;
    int          g_exec;
    logic [15:0] g_cmd;
    logic [15:0] g_par;
    logic [15:0] tmpx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(17'h0_0000);
        exp_q.push_back(17'h0_0000);
        m_last   = 0;
        m_issued = 0;
        m_count  = 16'h0000;
        m_grant  = 3'd0;
        m_err    = 1'b0;
        g_ph     = 0;
        g_exec   = 0;
        g_cmd    = 16'h0000;
        g_par    = 16'h0000;
        tmpx     = 16'h0000;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (consumed[i]) begin
                if (i == 0) void'(rq0.pop_front());
                else        void'(rq1.pop_front());
                held[i] = 1'b0;
            end
            if (!held[i]) begin
                if (((i == 0) ? rq0.size() : rq1.size()) > 0 &&
                    $urandom_range(0, 99) >= gap_pct) begin
                    held[i] = 1'b1;
                end
            end
            req_valid[i] = held[i];
            if (held[i]) begin
                req_cmd[16*i +: 16]   = (i == 0) ? rq0[0][31:16] : rq1[0][31:16];
                req_param[16*i +: 16] = (i == 0) ? rq0[0][15:0]  : rq1[0][15:0];
            end else begin
                req_cmd[16*i +: 16]   = 16'($urandom);
                req_param[16*i +: 16] = 16'($urandom);
            end
        end
        consumed = '0;
        if (vb_rand) vblank = 1'($urandom_range(0, 1));
    endtask

    // ---------------- one clock cycle: check, advance model, drive ----------------
    task automatic cycle();
        logic [16:0]     cur;
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] exp_ready;
        logic [15:0]     c;
        logic [15:0]     p;
        int              won;
        int              idx;
        logic            decide;
        @(negedge clk);
        if (clr) begin
            chk("ready_in_clr", 32'(req_ready), 32'd0);
            in_reset = 1'b1;
        end else begin
            if (in_reset) begin
                model_reset();
                in_reset = 1'b0;
            end
            cur       = exp_q.pop_front();
            decide    = (exp_q.size() == 0);
            won       = -1;
            exp_ready = '0;
            if (decide) begin
                elig = req_valid;
`ifdef GPU_SCHED_VBLANK_EN
                if (!vblank) elig = elig & NREQ'(1);
`endif
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (won < 0 && elig[idx]) won = idx;
                end
                if (won >= 0) exp_ready[won] = 1'b1;
            end
            chk("cpuline",     32'(cpuline),     32'(cur[15:0]));
            chk("busy",        32'(busy),        32'(cur[16]));
            chk("req_ready",   32'(req_ready),   32'(exp_ready));
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
            chk("cmd_count",   32'(cmd_count),   32'(m_count));
            chk("grant_id",    32'(grant_id),    32'(m_grant));

            // GPU model consumes whatever the DUT drives.
            case (g_ph)
                0: begin g_cmd = cpuline; g_ph = 1; end
                1: begin g_par = cpuline; g_ph = (g_cmd != 16'h0000) ? 2 : 0; end
                default: begin
                    g_exec++;
                    if (g_cmd == OP_SETX) tmpx = g_par;
                    g_ph = 0;
                end
            endcase

            m_err = 1'b0;
            if (decide) begin
                if (won >= 0) begin
                    c = req_cmd[16*won +: 16];
                    p = req_param[16*won +: 16];
                    m_last  = won;
                    m_grant = 3'(won);
                    consumed[won] = 1'b1;
                end
                if (won >= 0 && c >= 16'h00C0 && c <= 16'h00C6) begin
                    exp_q.push_back({1'b1, c});
                    exp_q.push_back({1'b1, p});
                    exp_q.push_back({1'b1, 16'h0000});
                    m_count = m_count + 16'd1;
                    m_issued++;
                end else begin
                    if (won >= 0) m_err = 1'b1;
                    exp_q.push_back(17'h0_0000);
                    exp_q.push_back(17'h0_0000);
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_drain(input string tag, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (rq0.size() == 0 && rq1.size() == 0 && held == '0) break;
            cycle();
        end
        repeat (6) cycle();
        chk(tag, 32'(rq0.size() + rq1.size()), 32'd0);
    endtask

    function automatic logic [15:0] rand_cmd(input int illegal_pct);
        logic [15:0] bad [6];
        bad[0] = 16'h0000; bad[1] = 16'h0055; bad[2] = 16'h00BF;
        bad[3] = 16'h00C7; bad[4] = 16'hFFFF; bad[5] = 16'h01C1;
        if ($urandom_range(0, 99) < illegal_pct) return bad[$urandom_range(0, 5)];
        return 16'h00C0 + 16'($urandom_range(0, 6));
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] saved;
        model_reset();

        // Reset held for a few cycles, released aligned with GPU phase 0.
        repeat (3) cycle();
        clr = 1'b0;

        // 1: single PUTC from requester 0.
        rq0.push_back({OP_PUTC, 16'h0041});
        run_drain("t1_drain", 12);
        chk("t1_cmd_count", 32'(cmd_count), 32'd1);

        // 2: both requesters continuously valid -> strict alternation.
        for (int i = 0; i < 8; i++) begin
            rq0.push_back({rand_cmd(0), 16'($urandom)});
            rq1.push_back({rand_cmd(0), 16'($urandom)});
        end
        run_drain("t2_drain", 80);

        // 3: illegal opcode from requester 1 is dropped.
        saved = m_count;
        rq1.push_back({16'h0055, 16'($urandom)});
        run_drain("t3_drain", 12);
        chk("t3_count_unchanged", 32'(cmd_count), 32'(saved));

        // 4: idle, then SETX 5 lands in phase with the GPU.
        repeat (10) cycle();
        rq0.push_back({OP_SETX, 16'h0005});
        run_drain("t4_drain", 12);
        chk("t4_tmpx", 32'(tmpx), 32'h0005);

`ifdef GPU_SCHED_VBLANK_EN
        // 5: requester 1 blocked outside vblank, requester 0 unaffected.
        vblank = 1'b0;
        rq1.push_back({OP_NL, 16'h0000});
        drive();
        repeat (10) cycle();
        chk("t5_req1_blocked", 32'(rq1.size()), 32'd1);
        rq0.push_back({OP_CLS, 16'h0000});
        drive();
        repeat (10) cycle();
        chk("t5_req0_served", 32'(rq0.size()), 32'd0);
        vblank = 1'b1;
        run_drain("t5_req1_after_vblank", 12);
`endif

        // Random traffic with gaps, illegal opcodes and vblank toggling.
        gap_pct = 30;
        vb_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rq0.push_back({rand_cmd(15), 16'($urandom)});
            rq1.push_back({rand_cmd(15), 16'($urandom)});
        end
        run_drain("rand_drain", 800);
        vb_rand = 1'b0;
        vblank  = 1'b1;
        gap_pct = 0;
        chk("gpu_exec_count", 32'(g_exec), 32'(m_issued));

        // 6: counter wrap from 0xFFFE after two more issues.
        dut.count_q = 16'hFFFE;
        m_count     = 16'hFFFE;
        rq0.push_back({OP_PUTC, 16'h0030});
        rq0.push_back({OP_PUTC, 16'h0031});
        run_drain("t6_drain", 20);
        chk("t6_wrap", 32'(cmd_count), 32'h0000);

        // 6b: clr in NOP1 with requester 0 valid: no ready, reset values.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 1 && exp_q[0][16] == 1'b0) break;
            cycle();
        end
        chk("t6_aligned_nop1", 32'(exp_q.size()), 32'd1);
        rq0.push_back({OP_BKSP, 16'h0000});
        drive();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        chk("t6_post_clr_count", 32'(cmd_count), 32'd0);
        run_drain("t6_after_clr_drain", 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
